// File: rtl/tank_decoder_seq.sv
// tank_decoder_seq
// Sequenced tank gate decoder. A dual-rail tank address plus a one-cycle
// transfer-in or transfer-out strobe is latched, the block waits for the
// requested minor-cycle slot, opens exactly one tank gate for one word time,
// and then pulses done.
//
// Ports:
//   clk       - block clock
//   rst       - synchronous, active-high reset
//   f_pos     - positive rail of the tank address
//   f_neg     - negative rail of the tank address
//   t_in      - one-cycle write-to-tank strobe
//   t_out     - one-cycle read-from-tank strobe
//   word_idx  - requested minor-cycle slot, sampled with the strobe
//   mc_start  - one-cycle pulse at the start of each minor cycle
//   mj_start  - major-cycle marker, only meaningful together with mc_start
//   abort     - cancels a pending or active transfer
//   tank_in   - one-hot tank in-gates
//   tank_out  - one-hot tank out-gates
//   busy      - a transfer is pending or active
//   done      - one-cycle pulse when a transfer completes
//   addr_err  - one-cycle pulse when a request is rejected
module tank_decoder_seq #(
  parameter int ADDR_BITS = 2,
  parameter int POS_BITS  = 4,
  parameter int WORD_CLKS = 18,
  localparam int NUM_TANKS = 2 ** ADDR_BITS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [ADDR_BITS-1:0] f_pos,
  input  logic [ADDR_BITS-1:0] f_neg,
  input  logic                 t_in,
  input  logic                 t_out,
  input  logic [POS_BITS-1:0]  word_idx,
  input  logic                 mc_start,
  input  logic                 mj_start,
  input  logic                 abort,
  output logic [NUM_TANKS-1:0] tank_in,
  output logic [NUM_TANKS-1:0] tank_out,
  output logic                 busy,
  output logic                 done,
  output logic                 addr_err
);

  // Gate counter is at least one bit wide so WORD_CLKS=1 still elaborates.
  localparam int CNT_BITS = (WORD_CLKS > 1) ? $clog2(WORD_CLKS) : 1;
  localparam logic [CNT_BITS-1:0] CNT_LOAD = CNT_BITS'(WORD_CLKS - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_GATE = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  logic [1:0]           state_r;
  logic [POS_BITS-1:0]  slot_r;
  logic [ADDR_BITS-1:0] tank_r;
  logic                 dir_in_r;
  logic [POS_BITS-1:0]  widx_r;
  logic [CNT_BITS-1:0]  cnt_r;
  logic [NUM_TANKS-1:0] tank_in_r;
  logic [NUM_TANKS-1:0] tank_out_r;
  logic                 busy_r;
  logic                 done_r;
  logic                 addr_err_r;

  logic [POS_BITS-1:0]  next_slot_s;
  logic                 addr_ok_s;
  logic                 idle_like_s;
  logic                 accept_s;
  logic                 reject_s;
  logic                 slot_hit_s;
  logic [NUM_TANKS-1:0] gate_mask_s;

  // One-hot select of a tank number.
  function automatic logic [NUM_TANKS-1:0] tank_onehot(input logic [ADDR_BITS-1:0] sel);
    logic [NUM_TANKS-1:0] mask;
    mask = {NUM_TANKS{1'b0}};
    for (int i = 0; i < NUM_TANKS; i++) begin
      mask[i] = (sel == ADDR_BITS'(i));
    end
    return mask;
  endfunction

  // Request qualification, slot look-ahead and gate select.
  always_comb begin
    next_slot_s = slot_r;
    if (mc_start) begin
      if (mj_start) begin
        next_slot_s = {POS_BITS{1'b0}};
      end else begin
        next_slot_s = slot_r + POS_BITS'(1);
      end
    end else begin
      next_slot_s = slot_r;
    end
    // Dual-rail address is valid only when every rail pair is complementary.
    addr_ok_s   = ((f_pos ^ f_neg) == {ADDR_BITS{1'b1}});
    idle_like_s = (state_r == ST_IDLE) || (state_r == ST_DONE);
    accept_s    = idle_like_s && (t_in ^ t_out) && addr_ok_s;
    reject_s    = idle_like_s && (t_in | t_out) && !((t_in ^ t_out) && addr_ok_s);
    // The match compares against the slot value being entered at this edge.
    slot_hit_s  = mc_start && (next_slot_s == widx_r);
    gate_mask_s = tank_onehot(tank_r);
  end

  // Free-running minor-cycle slot counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      slot_r <= {POS_BITS{1'b0}};
    end else begin
      slot_r <= next_slot_s;
    end
  end

  // Transfer sequencer with registered gate and status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      tank_r     <= {ADDR_BITS{1'b0}};
      dir_in_r   <= 1'b0;
      widx_r     <= {POS_BITS{1'b0}};
      cnt_r      <= {CNT_BITS{1'b0}};
      tank_in_r  <= {NUM_TANKS{1'b0}};
      tank_out_r <= {NUM_TANKS{1'b0}};
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      addr_err_r <= 1'b0;
    end else begin
      done_r     <= 1'b0;
      addr_err_r <= 1'b0;
      case (state_r)
        ST_IDLE, ST_DONE: begin
          tank_in_r  <= {NUM_TANKS{1'b0}};
          tank_out_r <= {NUM_TANKS{1'b0}};
          if (accept_s) begin
            tank_r   <= f_pos;
            dir_in_r <= t_in;
            widx_r   <= word_idx;
            busy_r   <= 1'b1;
            state_r  <= ST_WAIT;
          end else begin
            addr_err_r <= reject_s;
            busy_r     <= 1'b0;
            state_r    <= ST_IDLE;
          end
        end
        ST_WAIT: begin
          if (abort) begin
            busy_r  <= 1'b0;
            state_r <= ST_IDLE;
          end else if (slot_hit_s) begin
            cnt_r      <= CNT_LOAD;
            tank_in_r  <= dir_in_r ? gate_mask_s : {NUM_TANKS{1'b0}};
            tank_out_r <= dir_in_r ? {NUM_TANKS{1'b0}} : gate_mask_s;
            state_r    <= ST_GATE;
          end else begin
            state_r <= ST_WAIT;
          end
        end
        ST_GATE: begin
          if (abort) begin
            tank_in_r  <= {NUM_TANKS{1'b0}};
            tank_out_r <= {NUM_TANKS{1'b0}};
            busy_r     <= 1'b0;
            state_r    <= ST_IDLE;
          end else if (cnt_r == {CNT_BITS{1'b0}}) begin
            tank_in_r  <= {NUM_TANKS{1'b0}};
            tank_out_r <= {NUM_TANKS{1'b0}};
            busy_r     <= 1'b0;
            done_r     <= 1'b1;
            state_r    <= ST_DONE;
          end else begin
            cnt_r <= cnt_r - CNT_BITS'(1);
          end
        end
        default: begin
          tank_in_r  <= {NUM_TANKS{1'b0}};
          tank_out_r <= {NUM_TANKS{1'b0}};
          busy_r     <= 1'b0;
          state_r    <= ST_IDLE;
        end
      endcase
    end
  end

  assign tank_in  = tank_in_r;
  assign tank_out = tank_out_r;
  assign busy     = busy_r;
  assign done     = done_r;
  assign addr_err = addr_err_r;

endmodule

// File: tb/tb_tank_decoder_seq.sv
// Bench for tank_decoder_seq: a default instance (A) and a swept instance (B:
// 3 address bits, 5 slot bits, 1-clock word). Stimulus is applied on the
// falling edge; an integer transaction model predicts the outputs for the next
// cycle and pushes them into a per-instance queue. A monitor pops and compares
// just after each rising edge.
module tb_tank_decoder_seq;

  typedef struct {
    bit rst; bit ti; bit to; bit mc; bit mj; bit ab;
    int fp; int fn; int widx;
  } stim_t;

  typedef struct {
    int tin; int tout; bit busy; bit done; bit err;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A pins
  logic       a_rst, a_t_in, a_t_out, a_mc, a_mj, a_abort;
  logic [1:0] a_f_pos, a_f_neg;
  logic [3:0] a_word_idx;
  logic [3:0] a_tank_in, a_tank_out;
  logic       a_busy, a_done, a_err;

  // Instance B pins
  logic       b_rst, b_t_in, b_t_out, b_mc, b_mj, b_abort;
  logic [2:0] b_f_pos, b_f_neg;
  logic [4:0] b_word_idx;
  logic [7:0] b_tank_in, b_tank_out;
  logic       b_busy, b_done, b_err;

  tank_decoder_seq dut_a (
    .clk(clk), .rst(a_rst), .f_pos(a_f_pos), .f_neg(a_f_neg),
    .t_in(a_t_in), .t_out(a_t_out), .word_idx(a_word_idx),
    .mc_start(a_mc), .mj_start(a_mj), .abort(a_abort),
    .tank_in(a_tank_in), .tank_out(a_tank_out),
    .busy(a_busy), .done(a_done), .addr_err(a_err)
  );

  tank_decoder_seq #(.ADDR_BITS(3), .POS_BITS(5), .WORD_CLKS(1)) dut_b (
    .clk(clk), .rst(b_rst), .f_pos(b_f_pos), .f_neg(b_f_neg),
    .t_in(b_t_in), .t_out(b_t_out), .word_idx(b_word_idx),
    .mc_start(b_mc), .mj_start(b_mj), .abort(b_abort),
    .tank_in(b_tank_in), .tank_out(b_tank_out),
    .busy(b_busy), .done(b_done), .addr_err(b_err)
  );

  int checks = 0;
  int failures = 0;

  // Reference model state per instance (0 = A, 1 = B).
  int p_nt[2] = '{4, 8};
  int p_s[2]  = '{16, 32};
  int p_w[2]  = '{18, 1};
  int m_slot[2];
  int m_pend[2];   // 0 nothing outstanding, 1 waiting for slot, 2 gate open
  int m_tank[2];
  bit m_dir[2];
  int m_widx[2];
  int m_left[2];

  exp_t qa[$];
  exp_t qb[$];
  stim_t sa, sb;

  int run[2];
  int last_run[2];
  int done_cnt[2];
  int err_cnt[2];

  task automatic chk(input string name, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp_v);
    end
  endtask

  function automatic stim_t idle_stim();
    stim_t s;
    s = '{default: 0};
    return s;
  endfunction

  function automatic stim_t rand_stim(input int nbits, input int pbits);
    stim_t s;
    int r;
    int mask;
    mask   = (1 << nbits) - 1;
    s      = '{default: 0};
    s.rst  = ($urandom_range(399, 0) == 0);
    s.mc   = ($urandom_range(2, 0) == 0);
    s.mj   = s.mc && ($urandom_range(7, 0) == 0);
    s.ab   = ($urandom_range(149, 0) == 0);
    r      = $urandom_range(23, 0);
    s.ti   = (r == 0) || (r == 2) || (r == 4);
    s.to   = (r == 1) || (r == 3) || (r == 4);
    s.fp   = int'($urandom) & mask;
    s.fn   = ($urandom_range(5, 0) == 0) ? (int'($urandom) & mask) : (~s.fp & mask);
    s.widx = int'($urandom) & ((1 << pbits) - 1);
    return s;
  endfunction

  // Transaction-level model: returns the outputs expected after the next edge.
  task automatic model_step(input int k, input stim_t s, output exp_t e);
    int ns;
    bit valid;
    e = '{default: 0};
    if (s.rst) begin
      m_slot[k] = 0;
      m_pend[k] = 0;
    end else begin
      ns    = s.mc ? (s.mj ? 0 : (m_slot[k] + 1) % p_s[k]) : m_slot[k];
      valid = ((s.fp ^ s.fn) == p_nt[k] - 1);
      case (m_pend[k])
        1: begin
          if (s.ab) m_pend[k] = 0;
          else if (s.mc && ns == m_widx[k]) begin
            m_pend[k] = 2;
            m_left[k] = p_w[k];
          end
        end
        2: begin
          if (s.ab) m_pend[k] = 0;
          else begin
            m_left[k]--;
            if (m_left[k] == 0) begin
              m_pend[k] = 0;
              e.done = 1'b1;
            end
          end
        end
        default: begin
          if (s.ti || s.to) begin
            if (valid && !(s.ti && s.to)) begin
              m_pend[k] = 1;
              m_tank[k] = s.fp;
              m_dir[k]  = s.ti;
              m_widx[k] = s.widx;
            end else begin
              e.err = 1'b1;
            end
          end
        end
      endcase
      m_slot[k] = ns;
      if (m_pend[k] == 2) begin
        if (m_dir[k]) e.tin = 1 << m_tank[k];
        else e.tout = 1 << m_tank[k];
      end
      e.busy = (m_pend[k] != 0);
    end
  endtask

  // Apply one cycle of stimulus to both instances and queue the predictions.
  task automatic step();
    exp_t ea, eb;
    @(negedge clk);
    a_rst = sa.rst; a_t_in = sa.ti; a_t_out = sa.to; a_mc = sa.mc; a_mj = sa.mj;
    a_abort = sa.ab; a_f_pos = 2'(sa.fp); a_f_neg = 2'(sa.fn); a_word_idx = 4'(sa.widx);
    b_rst = sb.rst; b_t_in = sb.ti; b_t_out = sb.to; b_mc = sb.mc; b_mj = sb.mj;
    b_abort = sb.ab; b_f_pos = 3'(sb.fp); b_f_neg = 3'(sb.fn); b_word_idx = 5'(sb.widx);
    model_step(0, sa, ea);
    qa.push_back(ea);
    model_step(1, sb, eb);
    qb.push_back(eb);
    sa = idle_stim();
    sb = idle_stim();
  endtask

  task automatic compare(input int k, input logic [7:0] tin, input logic [7:0] tout,
                         input logic busy, input logic done, input logic err, input exp_t e);
    string nm;
    nm = (k == 0) ? "A" : "B";
    checks++;
    if ((tin !== 8'(e.tin)) || (tout !== 8'(e.tout)) || (busy !== e.busy) ||
        (done !== e.done) || (err !== e.err)) begin
      failures++;
      $display("FAIL outputs_%s t=%0t actual tin=%h tout=%h busy=%b done=%b err=%b expected tin=%h tout=%h busy=%b done=%b err=%b",
               nm, $time, tin, tout, busy, done, err, 8'(e.tin), 8'(e.tout), e.busy, e.done, e.err);
    end
    checks++;
    if ($countones(tin | tout) > 1) begin
      failures++;
      $display("FAIL onehot_%s t=%0t actual gates=%h required at most one bit", nm, $time, tin | tout);
    end
    if (|(tin | tout)) run[k]++;
    else if (run[k] > 0) begin
      last_run[k] = run[k];
      run[k] = 0;
    end
    if (done === 1'b1) done_cnt[k]++;
    if (err === 1'b1) err_cnt[k]++;
  endtask

  // Monitor: pop the prediction for this cycle and compare.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (qa.size() > 0) begin
        e = qa.pop_front();
        compare(0, {4'b0000, a_tank_in}, {4'b0000, a_tank_out}, a_busy, a_done, a_err, e);
      end
      if (qb.size() > 0) begin
        e = qb.pop_front();
        compare(1, b_tank_in, b_tank_out, b_busy, b_done, b_err, e);
      end
    end
  end

  initial begin
    int d0, e0, d1;
    sa = idle_stim(); sb = idle_stim();
    a_rst = 1'b1; a_t_in = 1'b0; a_t_out = 1'b0; a_mc = 1'b0; a_mj = 1'b0; a_abort = 1'b0;
    a_f_pos = 2'b00; a_f_neg = 2'b00; a_word_idx = 4'd0;
    b_rst = 1'b1; b_t_in = 1'b0; b_t_out = 1'b0; b_mc = 1'b0; b_mj = 1'b0; b_abort = 1'b0;
    b_f_pos = 3'b000; b_f_neg = 3'b000; b_word_idx = 5'd0;

    // Reset
    sa.rst = 1; sb.rst = 1; step();
    sa.rst = 1; sb.rst = 1; step();
    step(); step();

    // Basic write to tank 2 at slot 3 from slot 1, with extra strobes in WAIT and GATE
    d0 = done_cnt[0]; e0 = err_cnt[0];
    sa.mc = 1; sa.mj = 1; step();
    sa.mc = 1; step();
    sa.ti = 1; sa.fp = 2; sa.fn = 1; sa.widx = 3; step();
    sa.to = 1; sa.fp = 0; sa.fn = 3; sa.widx = 2; step();
    sa.mc = 1; step();
    step();
    sa.mc = 1; step();
    repeat (5) step();
    sa.ti = 1; sa.fp = 1; sa.fn = 2; sa.widx = 4; step();
    repeat (16) step();
    chk("basic_gate_len", last_run[0], 18);
    chk("basic_done_count", done_cnt[0] - d0, 1);
    chk("busy_strobe_no_err", err_cnt[0] - e0, 0);

    // Request accepted in the DONE cycle, then aborted at gate cycle 5
    d0 = done_cnt[0];
    sa.to = 1; sa.fp = 1; sa.fn = 2; sa.widx = 4; step();
    sa.mc = 1; step();
    repeat (18) step();
    sa.ti = 1; sa.fp = 3; sa.fn = 0; sa.widx = 5; step();
    step();
    chk("done_cycle_accept_busy", int'(a_busy), 1);
    sa.mc = 1; step();
    repeat (4) step();
    sa.ab = 1; step();
    step(); step();
    chk("abort_gate_len", last_run[0], 5);
    chk("abort_no_done", done_cnt[0] - d0, 1);
    chk("abort_busy_low", int'(a_busy), 0);

    // Reset at gate cycle 9, then slot must restart from 0
    d0 = done_cnt[0];
    sa.ti = 1; sa.fp = 3; sa.fn = 0; sa.widx = 7; step();
    sa.mc = 1; step();
    sa.mc = 1; step();
    repeat (8) step();
    sa.rst = 1; step();
    step(); step();
    chk("reset_gate_len", last_run[0], 9);
    chk("reset_no_done", done_cnt[0] - d0, 0);
    sa.ti = 1; sa.fp = 0; sa.fn = 3; sa.widx = 1; step();
    sa.mc = 1; step();
    repeat (21) step();
    chk("reset_slot_zero_gate", last_run[0], 18);
    chk("reset_slot_zero_done", done_cnt[0] - d0, 1);

    // Read from tank 0 with the slot wrapping from 15 to 0
    sa.mc = 1; sa.mj = 1; step();
    repeat (15) begin sa.mc = 1; step(); end
    sa.to = 1; sa.fp = 0; sa.fn = 3; sa.widx = 0; step();
    sa.mc = 1; step();
    repeat (21) step();
    chk("wrap_gate_len", last_run[0], 18);

    // Rejects: bad rail pair, and both strobes together
    e0 = err_cnt[0];
    sa.ti = 1; sa.fp = 3; sa.fn = 1; sa.widx = 2; step();
    step();
    sa.ti = 1; sa.to = 1; sa.fp = 2; sa.fn = 1; sa.widx = 2; step();
    step(); step();
    chk("reject_err_count", err_cnt[0] - e0, 2);
    chk("reject_busy_low", int'(a_busy), 0);

    // Swept instance: 1-clock gate at slot 31, then mj_start forced match on slot 0
    d1 = done_cnt[1];
    sb.mc = 1; sb.mj = 1; step();
    repeat (30) begin sb.mc = 1; step(); end
    sb.ti = 1; sb.fp = 5; sb.fn = 2; sb.widx = 31; step();
    sb.mc = 1; step();
    step(); step(); step();
    chk("sweep_slot31_gate_len", last_run[1], 1);
    chk("sweep_slot31_done", done_cnt[1] - d1, 1);
    sb.mc = 1; step();
    sb.to = 1; sb.fp = 7; sb.fn = 0; sb.widx = 0; step();
    sb.mc = 1; sb.mj = 1; step();
    step(); step(); step();
    chk("sweep_mj_gate_len", last_run[1], 1);
    chk("sweep_mj_done", done_cnt[1] - d1, 2);

    // Randomized traffic on both instances
    repeat (4000) begin
      sa = rand_stim(2, 4);
      sb = rand_stim(3, 5);
      step();
    end
    step(); step();
    @(posedge clk);
    #2;
    chk("queue_a_drained", qa.size(), 0);
    chk("queue_b_drained", qb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
